bcd_seg_scan: RTL and testbench

- Downstream consumer of the binary-to-BCD stage.
- Accepts a packed word of DIGITS BCD digits through a valid/ready handshake and double-buffers it.
- Time-multiplexes the digits onto one shared 7-segment bus with a one-hot digit enable.
- Display updates only at frame boundaries, so a new value never tears mid-scan.

---
 rtl/bcd_seg_scan.sv | 117 +++++++++++
 tb/tb_bcd_seg_scan.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
// Double-buffered BCD digit scanner driving a shared 7-segment bus with one-hot digit enables.
// Optional leading-zero blanking is enabled by defining BCD_SEG_SCAN_LZB_EN.
module bcd_seg_scan #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  bcd_valid,
  output logic                  bcd_ready,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BW = 4 * DIGITS;

  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [BW-1:0]     r_shadow;
  logic [BW-1:0]     r_disp;
  logic              r_pending;
  logic              r_ready;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;

  logic              w_last_cnt;
  logic              w_boundary;
  logic [DIGITS-1:0] w_an;
  logic [3:0]        w_digit;
  logic              w_blank;
  logic [6:0]        w_seg;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'h3F;
      4'd1:    f_decode = 7'h06;
      4'd2:    f_decode = 7'h5B;
      4'd3:    f_decode = 7'h4F;
      4'd4:    f_decode = 7'h66;
      4'd5:    f_decode = 7'h6D;
      4'd6:    f_decode = 7'h7D;
      4'd7:    f_decode = 7'h07;
      4'd8:    f_decode = 7'h7F;
      4'd9:    f_decode = 7'h6F;
      default: f_decode = 7'h40;
    endcase
  endfunction

  assign w_last_cnt = (r_cnt == CW'(PRESCALE - 1));
  assign w_boundary = w_last_cnt && (r_idx == IW'(DIGITS - 1));

  // Select the active digit, its enable and (optionally) whether it is a leading zero.
  always_comb begin
    w_an    = '0;
    w_digit = 4'd0;
    w_blank = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (r_idx == IW'(k)) begin
        w_an[k] = 1'b1;
        w_digit = r_disp[4*k +: 4];
      end
    end
`ifdef BCD_SEG_SCAN_LZB_EN
    begin
      logic w_hi_zero;
      w_hi_zero = 1'b1;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
        w_hi_zero = w_hi_zero && (r_disp[4*k +: 4] == 4'd0);
        if ((k > 0) && (r_idx == IW'(k))) w_blank = w_hi_zero;
      end
    end
`endif
    w_seg = w_blank ? 7'h00 : f_decode(w_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shadow  <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
      r_ready   <= 1'b1;
      r_an      <= '0;
      r_seg     <= 7'h00;
    end else begin
      if (w_last_cnt) begin
        r_cnt <= '0;
        r_idx <= w_boundary ? '0 : r_idx + IW'(1);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      // Capture needs ready, which implies nothing pending, so it never collides with commit.
      if (bcd_valid && r_ready) begin
        r_shadow  <= bcd_in;
        r_pending <= 1'b1;
        r_ready   <= 1'b0;
      end else if (w_boundary && r_pending) begin
        r_disp    <= r_shadow;
        r_pending <= 1'b0;
        r_ready   <= 1'b1;
      end

      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign bcd_ready = r_ready;
  assign an        = r_an;
  assign seg       = r_seg;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Randomized and directed bench for bcd_seg_scan against a cycle-count based reference model.
module tb_bcd_seg_scan;

  localparam int unsigned D     = 2;
  localparam int unsigned P     = 4;
  localparam int unsigned FRAME = D * P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bcd_in = 8'h00;
  logic       bcd_valid = 1'b0;
  logic       bcd_ready;
  logic [1:0] an;
  logic [6:0] seg;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position in the scan is derived from edges since reset.
  int unsigned m_n = 0;
  logic [7:0]  m_disp = 8'h00;
  logic [7:0]  m_shadow = 8'h00;
  logic        m_pend = 1'b0;
  logic        m_ready = 1'b1;
  logic [1:0]  e_an = 2'b00;
  logic [6:0]  e_seg = 7'h00;
  logic [6:0]  obs [2];

  bcd_seg_scan #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .bcd_ready (bcd_ready),
    .an        (an),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [7:0] v, input int unsigned k);
    logic [7:0] hi;
    logic [6:0] lut [16];
    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    hi = v >> (4 * k);
`ifdef BCD_SEG_SCAN_LZB_EN
    if (k > 0 && hi == 8'h00) return 7'h00;
`endif
    return lut[hi[3:0]];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    int unsigned idx;
    bcd_valid = v;
    bcd_in    = d;
    rst       = r;
    @(posedge clk);
    if (r) begin
      m_n = 0; m_disp = 8'h00; m_shadow = 8'h00; m_pend = 1'b0; m_ready = 1'b1;
      e_an = 2'b00; e_seg = 7'h00;
    end else begin
      idx   = (m_n / P) % D;
      e_an  = 2'(1 << idx);
      e_seg = ref_seg(m_disp, idx);
      if (v && m_ready) begin
        m_shadow = d; m_pend = 1'b1; m_ready = 1'b0;
      end else if ((m_n % FRAME) == FRAME - 1 && m_pend) begin
        m_disp = m_shadow; m_pend = 1'b0; m_ready = 1'b1;
      end
      m_n++;
    end
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("ready", 32'(bcd_ready), 32'(m_ready));
    if (an == 2'b01) obs[0] = seg;
    else if (an == 2'b10) obs[1] = seg;
  endtask

  task automatic idle(input int unsigned nc);
    for (int i = 0; i < int'(nc); i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic load(input logic [7:0] d);
    int guard = 0;
    while (!bcd_ready && guard < 4 * int'(FRAME)) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
    end
    check("load_ready", 32'(bcd_ready), 32'd1);
    step(1'b1, d, 1'b0);
  endtask

  task automatic scan(input string tag, input logic [6:0] e0, input logic [6:0] e1);
    obs[0] = 7'h55;
    obs[1] = 7'h55;
    idle(FRAME);
    check({tag, "_d0"}, 32'(obs[0]), 32'(e0));
    check({tag, "_d1"}, 32'(obs[1]), 32'(e1));
  endtask

  initial begin
    // Reset and first edges
    repeat (3) step(1'b0, 8'h00, 1'b1);
    check("rst_an", 32'(an), 32'd0);
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_ready", 32'(bcd_ready), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    check("first_an", 32'(an), 32'h1);
    check("first_seg", 32'(seg), 32'h3F);
    idle(2 * FRAME);

    // Load 12, then back-pressure 99 while pending
    load(8'h12);
    check("ready_low", 32'(bcd_ready), 32'd0);
    repeat (3) step(1'b1, 8'h99, 1'b0);
    idle(2 * FRAME);
    scan("v12", 7'h5B, 7'h06);
    load(8'h99);
    idle(2 * FRAME);
    scan("v99", 7'h6F, 7'h6F);

    // Invalid digit
    load(8'h3A);
    idle(2 * FRAME);
    scan("v3A", 7'h40, 7'h4F);

    // Reset while 45 is pending
    load(8'h45);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("mid_rst_an", 32'(an), 32'd0);
    check("mid_rst_seg", 32'(seg), 32'd0);
    check("mid_rst_ready", 32'(bcd_ready), 32'd1);
    idle(2 * FRAME);
    scan("post_rst", 7'h3F, 7'h3F);

    // Leading zeros
    load(8'h05);
    idle(2 * FRAME);
`ifdef BCD_SEG_SCAN_LZB_EN
    scan("v05", 7'h6D, 7'h00);
`else
    scan("v05", 7'h6D, 7'h3F);
`endif
    load(8'h00);
    idle(2 * FRAME);
`ifdef BCD_SEG_SCAN_LZB_EN
    scan("v00", 7'h3F, 7'h00);
`else
    scan("v00", 7'h3F, 7'h3F);
`endif

    // Random traffic with occasional resets
    repeat (800) begin
      step(($urandom % 3) == 0, 8'($urandom), ($urandom % 150) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
